// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: producer latencies and scoreboard entry indices
// for the HI/LO special registers that sit above the GPR entries.
package cpu_pkg;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 7;

    localparam int GPR_AW = 5;
    localparam int HI_IDX = 2 ** GPR_AW;
    localparam int LO_IDX = HI_IDX + 1;

    // Index helpers for scoreboards built with a non-default GPR address width.
    function automatic int hi_idx(input int aw);
        return 2 ** aw;
    endfunction

    function automatic int lo_idx(input int aw);
        return (2 ** aw) + 1;
    endfunction

endpackage

// File: rtl/id_scoreboard_counter.sv
// One scoreboard entry: a countdown of cycles until the producer's result can
// be forwarded, frozen by hold and reloaded with the longer of old/new latency.
module sb_counter #(
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          load,
    input  logic [LW-1:0] lat,
    output logic [LW-1:0] count,
    output logic          busy
);

    logic [LW-1:0] count_reg;
    logic [LW-1:0] count_next;
    logic [LW-1:0] dec;
    logic          busy_reg;

    always_comb begin
        dec        = (count_reg == '0) ? '0 : count_reg - LW'(1);
        count_next = count_reg;
        if (!hold) begin
            count_next = dec;
            // An older, longer producer must never be shortened by a newer one.
            if (load && (lat > dec)) begin
                count_next = lat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            busy_reg  <= (count_next != '0);
        end
    end

    assign count = count_reg;
    assign busy  = busy_reg;

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage hazard scoreboard: per-register countdowns (GPRs plus HI/LO)
// that stall an instruction until every source it reads is forwardable.
module id_scoreboard
    import cpu_pkg::*;
#(
    parameter int NSRC = 2,
    parameter int AW   = 5,
    parameter int LW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 issue_valid,
    input  logic                 issue_we,
    input  logic [AW-1:0]        issue_waddr,
    input  logic                 issue_hi_we,
    input  logic                 issue_lo_we,
    input  logic [LW-1:0]        issue_lat,
    input  logic [NSRC-1:0]      src_en,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic                 src_hi,
    input  logic                 src_lo,
    output logic                 stallreq,
    output logic [(2**AW)+1:0]   busy
);

    localparam int NGPR = 2 ** AW;
    localparam int NE   = NGPR + 2;
    localparam int HI   = hi_idx(AW);
    localparam int LO   = lo_idx(AW);

    logic [LW-1:0]   cnt [NE];
    logic [NSRC-1:0] src_conf;
    logic            hilo_conf;
    logic            accept;

    genvar gi;

    // Conflicts are judged on pre-update counters so an instruction never
    // stalls on its own destination.
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [AW-1:0] addr;
            assign addr         = src_addr[gi*AW +: AW];
            assign src_conf[gi] = src_en[gi] && (addr != '0) && (cnt[addr] != '0);
        end
    endgenerate

    assign hilo_conf = (src_hi && (cnt[HI] != '0)) || (src_lo && (cnt[LO] != '0));
    assign stallreq  = issue_valid && ((|src_conf) || hilo_conf);
    assign accept    = issue_valid && !stallreq && !hold;

    // $0 is hardwired: it never has a pending producer.
    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    generate
        for (gi = 1; gi < NGPR; gi++) begin : g_gpr
            sb_counter #(.LW(LW)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .hold  (hold),
                .load  (accept && issue_we && (issue_waddr == AW'(gi))),
                .lat   (issue_lat),
                .count (cnt[gi]),
                .busy  (busy[gi])
            );
        end
    endgenerate

    sb_counter #(.LW(LW)) u_hi (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .load  (accept && issue_hi_we),
        .lat   (issue_lat),
        .count (cnt[HI]),
        .busy  (busy[HI])
    );

    sb_counter #(.LW(LW)) u_lo (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .load  (accept && issue_lo_we),
        .lat   (issue_lat),
        .count (cnt[LO]),
        .busy  (busy[LO])
    );

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard (NSRC=3): directed vector table, hand-written
// multi-cycle sequences, then random traffic against a ready-time model.
module tb_id_scoreboard;

    localparam int NSRC = 3;
    localparam int AW   = 5;
    localparam int LW   = 3;
    localparam int NE   = 34;
    localparam int HI   = 32;
    localparam int LO   = 33;

    logic               clk = 1'b0;
    logic               rst;
    logic               hold;
    logic               issue_valid;
    logic               issue_we;
    logic [AW-1:0]      issue_waddr;
    logic               issue_hi_we;
    logic               issue_lo_we;
    logic [LW-1:0]      issue_lat;
    logic [NSRC-1:0]    src_en;
    logic [NSRC*AW-1:0] src_addr;
    logic               src_hi;
    logic               src_lo;
    logic               stallreq;
    logic [NE-1:0]      busy;

    int n_checks = 0;
    int n_pass   = 0;

    id_scoreboard #(.NSRC(NSRC), .AW(AW), .LW(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_waddr (issue_waddr),
        .issue_hi_we (issue_hi_we),
        .issue_lo_we (issue_lo_we),
        .issue_lat   (issue_lat),
        .src_en      (src_en),
        .src_addr    (src_addr),
        .src_hi      (src_hi),
        .src_lo      (src_lo),
        .stallreq    (stallreq),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: each entry remembers the (hold-free) cycle number at
    // which its value becomes forwardable; it is busy until that cycle.
    int unsigned t_now = 0;
    int unsigned ready [NE];

    function automatic bit m_busy(input int e);
        return ready[e] > t_now;
    endfunction

    function automatic bit m_stall();
        bit c = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            int a = int'(src_addr[i*AW +: AW]);
            if (src_en[i] && a != 0 && m_busy(a)) c = 1'b1;
        end
        if (src_hi && m_busy(HI)) c = 1'b1;
        if (src_lo && m_busy(LO)) c = 1'b1;
        return issue_valid && c;
    endfunction

    function automatic logic [NE-1:0] m_busy_vec();
        logic [NE-1:0] v = '0;
        for (int e = 0; e < NE; e++) v[e] = m_busy(e);
        return v;
    endfunction

    task automatic m_update();
        bit acc = issue_valid && !m_stall() && !hold;
        int unsigned r = t_now + int'(issue_lat) + 1;
        if (rst) begin
            for (int e = 0; e < NE; e++) ready[e] = 0;
        end else if (!hold) begin
            if (acc) begin
                if (issue_we && issue_waddr != 0 && r > ready[issue_waddr]) ready[issue_waddr] = r;
                if (issue_hi_we && r > ready[HI]) ready[HI] = r;
                if (issue_lo_we && r > ready[LO]) ready[LO] = r;
            end
            t_now++;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: sample outputs at the falling edge, advance the model, clock.
    task automatic tick(input bit chk, output bit st, output logic [NE-1:0] bz);
        @(negedge clk);
        st = stallreq;
        bz = busy;
        if (chk) begin
            check("rand_stall", 64'(st), 64'(m_stall()));
            check("rand_busy", 64'(bz), 64'(m_busy_vec()));
        end
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hold = 0; issue_valid = 0; issue_we = 0; issue_waddr = '0;
        issue_hi_we = 0; issue_lo_we = 0; issue_lat = '0;
        src_en = '0; src_addr = '0; src_hi = 0; src_lo = 0;
    endtask

    task automatic set_issue(input bit we, input int waddr, input bit hi, input bit lo, input int lat);
        issue_valid = 1; issue_we = we; issue_waddr = AW'(waddr);
        issue_hi_we = hi; issue_lo_we = lo; issue_lat = LW'(lat);
    endtask

    task automatic set_src(input logic [2:0] en, input int a0, input int a1, input int a2,
                           input bit shi, input bit slo);
        src_en = en; src_addr = {AW'(a2), AW'(a1), AW'(a0)}; src_hi = shi; src_lo = slo;
    endtask

    // Keeps the current instruction presented until accepted; counts stall cycles.
    task automatic count_stalls(input int hold_a, input int hold_b, output int n);
        bit st;
        logic [NE-1:0] bz;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            hold = (k == hold_a) || (k == hold_b);
            tick(0, st, bz);
            if (st) n++;
            if (!st && !hold) break;
        end
        set_idle();
    endtask

    typedef struct {
        bit         valid, we, hi_we, lo_we;
        int         waddr, lat;
        logic [2:0] en;
        int         s0, s1, s2;
        bit         shi, slo;
        bit         exp_stall;
        int         bidx;
        bit         exp_busy;
    } vec_t;

    function automatic vec_t mkv(input bit valid, input bit we, input int waddr, input bit hi_we,
                                 input bit lo_we, input int lat, input logic [2:0] en, input int s0,
                                 input int s1, input int s2, input bit shi, input bit slo,
                                 input bit es, input int bidx, input bit eb);
        vec_t v;
        v.valid = valid; v.we = we; v.waddr = waddr; v.hi_we = hi_we; v.lo_we = lo_we;
        v.lat = lat; v.en = en; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.shi = shi; v.slo = slo;
        v.exp_stall = es; v.bidx = bidx; v.exp_busy = eb;
        return v;
    endfunction

    initial begin
        vec_t          tbl[$];
        bit            st;
        logic [NE-1:0] bz;
        int            n;

        // Load-use: lw $5 (lat 1), add reading $5 stalls one cycle.
        tbl.push_back(mkv(1,1,5,0,0,1, 3'b000,0,0,0,0,0, 0,5,0));
        tbl.push_back(mkv(1,1,10,0,0,0, 3'b011,5,6,0,0,0, 1,5,1));
        tbl.push_back(mkv(1,1,10,0,0,0, 3'b011,5,6,0,0,0, 0,5,0));
        // div (lat 7) writing HI/LO, then mflo: seven stall cycles.
        tbl.push_back(mkv(1,0,0,1,1,7, 3'b000,0,0,0,0,0, 0,LO,0));
        for (int i = 0; i < 7; i++) tbl.push_back(mkv(1,1,2,0,0,0, 3'b000,0,0,0,0,1, 1,LO,1));
        tbl.push_back(mkv(1,1,2,0,0,0, 3'b000,0,0,0,0,1, 0,LO,0));
        // Register zero never becomes busy.
        tbl.push_back(mkv(1,1,0,0,0,3, 3'b000,0,0,0,0,0, 0,0,0));
        tbl.push_back(mkv(1,1,11,0,0,0, 3'b001,0,0,0,0,0, 0,0,0));
        tbl.push_back(mkv(1,1,11,0,0,0, 3'b001,0,0,0,0,0, 0,0,0));
        // WAW: $8 lat 5 then lat 1; the longer producer governs the stall.
        tbl.push_back(mkv(1,1,8,0,0,5, 3'b000,0,0,0,0,0, 0,8,0));
        tbl.push_back(mkv(1,1,8,0,0,1, 3'b000,0,0,0,0,0, 0,8,1));
        for (int i = 0; i < 4; i++) tbl.push_back(mkv(1,1,12,0,0,0, 3'b001,8,0,0,0,0, 1,8,1));
        tbl.push_back(mkv(1,1,12,0,0,0, 3'b001,8,0,0,0,0, 0,8,0));

        set_idle();
        rst = 1;
        tick(0, st, bz);
        tick(0, st, bz);
        rst = 0;
        tick(0, st, bz);
        check("reset_busy", 64'(bz), 64'(0));
        check("reset_stall", 64'(st), 64'(0));

        foreach (tbl[i]) begin
            set_idle();
            set_issue(tbl[i].we, tbl[i].waddr, tbl[i].hi_we, tbl[i].lo_we, tbl[i].lat);
            issue_valid = tbl[i].valid;
            set_src(tbl[i].en, tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].shi, tbl[i].slo);
            tick(0, st, bz);
            $display("vec %0d: stallreq=%b busy[%0d]=%b", i, st, tbl[i].bidx, bz[tbl[i].bidx]);
            check("vec_stall", 64'(st), 64'(tbl[i].exp_stall));
            check("vec_busy", 64'(bz[tbl[i].bidx]), 64'(tbl[i].exp_busy));
        end
        set_idle();

        // div then mflo with two hold cycles in the wait: 7 + 2 stalls.
        set_issue(0, 0, 1, 1, 7);
        tick(0, st, bz);
        set_idle();
        issue_valid = 1;
        set_src(3'b000, 0, 0, 0, 0, 1);
        count_stalls(1, 2, n);
        $display("div+mflo with hold: %0d stall cycles", n);
        check("div_hold_stalls", 64'(n), 64'(9));

        // addu $3,$3,$4 with $4 counter at 2: stalls on $4 only.
        set_issue(1, 4, 0, 0, 2);
        tick(0, st, bz);
        set_idle();
        set_issue(1, 3, 0, 0, 0);
        set_src(3'b011, 3, 4, 0, 0, 0);
        count_stalls(-1, -1, n);
        $display("addu self-dep: %0d stall cycles", n);
        check("selfdep_stalls", 64'(n), 64'(2));

        // Three sources: $6 nearly ready, $7 at 4; stall follows the busiest.
        set_issue(1, 6, 0, 0, 2);
        tick(0, st, bz);
        set_issue(1, 7, 0, 0, 4);
        tick(0, st, bz);
        set_idle();
        set_issue(1, 13, 0, 0, 0);
        set_src(3'b101, 6, 0, 7, 0, 0);
        count_stalls(-1, -1, n);
        $display("three-source: %0d stall cycles", n);
        check("multisrc_stalls", 64'(n), 64'(4));

        // No stall request without a valid instruction, even while busy.
        set_issue(1, 9, 0, 0, 5);
        tick(0, st, bz);
        set_idle();
        set_src(3'b001, 9, 0, 0, 0, 0);
        tick(0, st, bz);
        $display("invalid read of busy $9: stallreq=%b busy[9]=%b", st, bz[9]);
        check("novalid_stall", 64'(st), 64'(0));
        check("novalid_busy9", 64'(bz[9]), 64'(1));
        set_idle();
        for (int i = 0; i < 6; i++) tick(0, st, bz);

        // Reset while the LO counter is at 4: pending mflo goes through next cycle.
        set_issue(0, 0, 1, 1, 7);
        tick(0, st, bz);
        set_idle();
        for (int i = 0; i < 3; i++) tick(0, st, bz);
        issue_valid = 1;
        set_src(3'b000, 0, 0, 0, 0, 1);
        rst = 1;
        tick(0, st, bz);
        check("prereset_stall", 64'(st), 64'(1));
        rst = 0;
        tick(0, st, bz);
        $display("after reset: stallreq=%b busy=%h", st, bz);
        check("postreset_busy", 64'(bz), 64'(0));
        check("postreset_stall", 64'(st), 64'(0));
        set_idle();

        // Random traffic against the ready-time model.
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 63) == 0);
            hold        = ($urandom_range(0, 4) == 0);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_we    = ($urandom_range(0, 2) != 0);
            issue_waddr = AW'($urandom_range(0, 7));
            issue_hi_we = ($urandom_range(0, 5) == 0);
            issue_lo_we = ($urandom_range(0, 5) == 0);
            issue_lat   = LW'($urandom_range(0, 7));
            src_en      = NSRC'($urandom);
            src_addr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            src_hi      = ($urandom_range(0, 4) == 0);
            src_lo      = ($urandom_range(0, 4) == 0);
            tick(1, st, bz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised hazard scoreboard for the decode stage. It replaces the single-cycle load-use check (EX holds a load whose destination matches rs or rt) with per-register countdown counters. Any producer latency (loads, mul/div, future multicycle units) and any number of source operands stall decode for exactly as long as needed. It sits beside the register file in ID, drives `stallreq` to the stall controller, and tracks HI and LO as two extra scoreboard entries.

## Interface
- `NSRC`, default 2: number of source operands checked per instruction.
- `AW`, default 5: GPR address width; there are 2^AW GPR entries.
- `LW`, default 3: latency counter width; the maximum latency is 2^LW-1.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `hold`  in  1: pipeline stall from the controller (any of stall[3:5]). Freezes counters.
- `issue_valid`  in  1: the instruction in ID is valid (ce).
- `issue_we`  in  1: the instruction writes GPR `issue_waddr`.
- `issue_waddr`  in  AW: destination GPR.
- `issue_hi_we`, `issue_lo_we`  in  1 each: the instruction writes HI / LO.
- `issue_lat`  in  LW: cycles from issue until the result can be forwarded. 0 means forwardable to the next instruction. Load = 1, div = 2^LW-1.
- `src_en`  in  NSRC: per-source read enable.
- `src_addr`  in  NSRC*AW: source GPR addresses, packed with src 0 in the LSBs.
- `src_hi`, `src_lo`  in  1 each: the instruction reads HI / LO (mfhi/mflo).
- `stallreq`  out  1: combinational stall request to the controller.
- `busy`  out  2^AW+2: registered per-entry flag meaning counter ≠ 0. Bit 2^AW is HI and bit 2^AW+1 is LO.

## Operation
- State: one LW-bit counter per GPR (entry 0 is always 0), plus one each for HI and LO. All counters reset to 0.
- Conflict: source i conflicts when `src_en[i]` is high, `src_addr[i]` ≠ 0, and that counter is ≠ 0. `src_hi`/`src_lo` conflict the same way against the HI/LO counter.
- `stallreq` = `issue_valid` & (any conflict). It is computed from pre-update counter values, so the instruction's own destination never stalls itself.
- Accept: `accept` = `issue_valid` & !`stallreq` & !`hold`.
- Counter update per cycle, for each entry:
  - If `hold` is high, the counter keeps its value.
  - Otherwise the decremented value is d = (c == 0) ? 0 : c-1.
  - If `accept` targets this entry (GPR via `issue_we`/`issue_waddr`, or HI/LO via the `*_we` flags), the counter loads max(d, `issue_lat`). An older, longer producer is never shortened.
  - Otherwise the counter loads d.
- `issue_we` with `issue_waddr` = 0 changes nothing.
- `busy` reflects the counters after update, with one register stage.

## Timing
- `stallreq` has zero-cycle combinational latency from the `src_*` inputs and counter state.
- Producer issued in cycle T with latency L, `hold` low throughout:
  - A dependent instruction stalls in cycles T+1 .. T+L.
  - It is accepted in cycle T+L+1.
  - L = 0 never stalls.
- `hold` cycles extend the window one-for-one.
- Simultaneous decrement and issue to the same entry: the issue value wins via the max rule.
- `rst` mid-operation: all counters and `busy` are 0 in the next cycle, and `stallreq` is low after that.
- `stallreq` is low whenever `issue_valid` is low, even while `busy` is nonzero.

## Structure
- Shared package `cpu_pkg` holds:
  - the latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL, LAT_DIV;
  - the HI/LO entry index constants HI_IDX = 2^AW and LO_IDX = 2^AW+1.
- One natural sub-module, `sb_counter`: a single LW-bit entry with hold, decrement, and load-max. It is instantiated 2^AW+1 times via generate; GPR entry 0 is tied to 0.

## Test plan
- Load-use:
  - Stimulus: lw $5 accepted with lat 1, then add with src $5 the next cycle.
  - Required: `stallreq` is 1 for one cycle, the add is accepted in the second cycle, and `busy[5]` is 1 for exactly one cycle.
- Divide then mflo:
  - Stimulus: div accepted with lat 7 and both `issue_hi_we` and `issue_lo_we` set, followed immediately by mflo (`src_lo`).
  - Required: 7 stall cycles. With 2 `hold` cycles inserted it becomes 9.
- Register zero:
  - Stimulus: write $0 with lat 3, then read $0.
  - Required: no stall and `busy[0]` stays 0.
- WAW max rule:
  - Stimulus: write $8 with lat 5, then one cycle later write $8 with lat 1, then read $8.
  - Required: the counter holds 4, then 3; the stall ends 5 cycles after the first issue.
- Self-dependency and multi-source:
  - Stimulus: `addu $3,$3,$4` with $4 counter = 2 and $3 idle; NSRC=3 variant with src2 busy.
  - Required: the addu stalls 2 cycles, on $4 only. In the NSRC=3 variant, the stall follows the busiest source.
- Reset mid-div:
  - Stimulus: assert `rst` at counter = 4.
  - Required: all `busy` bits are 0 the next cycle and a pending mflo is accepted immediately.
